id_ex_stage: RTL and testbench

ID/EX pipeline register of the 5-stage RV32I pipeline with integrated load-use hazard detection. Captures the decode-stage control bundle (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch, JalType) plus the operands and register indices, and presents them to EX one cycle later. Detects load-use hazards, holds PC and IF/ID, and injects bubbles on a hazard or on a taken-branch flush. Keeps saturating counters of stall and flush bubbles for performance monitoring.

---
 rtl/riscv_pipe_pkg.sv | 45 ++++
 rtl/load_use_detect.sv | 34 +++
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared opcodes, control bundle and source-use decode for the RV32I pipe
//
// Contents:
//   opcode constants  R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR, LUI
//   ctrl_t            11-bit decoder control bundle, MSB first:
//                     {spare, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
//                      alu_op[1:0], branch, jal_type[1:0]}
//   uses_rs()         returns {use_rs2, use_rs1} for an opcode
package riscv_pipe_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;

    // The named fields total ten bits; the top bit of the 11-bit bundle is a
    // spare that is carried through to EX untouched.
    typedef struct packed {
        logic       spare;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       branch;
        logic [1:0] jal_type;
    } ctrl_t;

    function automatic logic [1:0] uses_rs(input logic [6:0] opcode);
        logic [1:0] use_rs;
        use_rs = 2'b00;
        case (opcode)
            R_TYPE, SW, BR:   use_rs = 2'b11;
            I_TYPE, LW, JALR: use_rs = 2'b01;
            default:          use_rs = 2'b00;
        endcase
        return use_rs;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
//
// Ports:
//   id_valid_i, id_opcode_i, id_rs1_i, id_rs2_i  instruction currently in ID
//   ex_valid_i, ex_mem_read_i, ex_rd_i           instruction currently in EX
//   hazard_o                                     ID reads the register a load in EX is about to write
module load_use_detect
    import riscv_pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             id_valid_i,
    input  logic [6:0]       id_opcode_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rd_i,
    output logic             hazard_o
);

    logic [1:0] use_rs;
    logic       match_rs1;
    logic       match_rs2;

    assign use_rs    = uses_rs(id_opcode_i);
    assign match_rs1 = use_rs[0] && (ex_rd_i == id_rs1_i);
    assign match_rs2 = use_rs[1] && (ex_rd_i == id_rs2_i);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard_o = id_valid_i && ex_valid_i && ex_mem_read_i
                   && (ex_rd_i != '0) && (match_rs1 || match_rs2);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and bubble counters
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   id_*                         decoded instruction, control bundle and operands from ID
//   ex_flush                     taken branch/jump in EX; replaces the ID instruction with a bubble
//   ex_*                         registered copy presented to EX one cycle later
//   stall                        combinational; hold PC and IF/ID this cycle
//   stall_cnt, flush_cnt         saturating counts of hazard and flush bubbles
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [10:0]       id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              ex_flush,
    output logic              ex_valid,
    output logic [10:0]       ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              valid_q,  valid_d;
    ctrl_t             ctrl_q,   ctrl_d;
    logic [DATA_W-1:0] pc_q,     pc_d;
    logic [DATA_W-1:0] rd1_q,    rd1_d;
    logic [DATA_W-1:0] rd2_q,    rd2_d;
    logic [DATA_W-1:0] imm_q,    imm_d;
    logic [REG_W-1:0]  rs1_q,    rs1_d;
    logic [REG_W-1:0]  rs2_q,    rs2_d;
    logic [REG_W-1:0]  rd_q,     rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [6:0]        funct7_q, funct7_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              hazard;

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .id_valid_i    (id_valid),
        .id_opcode_i   (id_opcode),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_i       (rd_q),
        .hazard_o      (hazard)
    );

    // A flush already discards the ID instruction, so holding IF/ID would be pointless.
    assign stall = hazard && !ex_flush && !reset;

    always_comb begin
        // Default: bubble, counters unchanged.
        valid_d     = 1'b0;
        ctrl_d      = '0;
        pc_d        = '0;
        rd1_d       = '0;
        rd2_d       = '0;
        imm_d       = '0;
        rs1_d       = '0;
        rs2_d       = '0;
        rd_d        = '0;
        funct3_d    = '0;
        funct7_d    = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (ex_flush) begin
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (hazard) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            valid_d  = id_valid;
            ctrl_d   = id_valid ? ctrl_t'(id_ctrl) : '0;
            pc_d     = id_pc;
            rd1_d    = id_rd1;
            rd2_d    = id_rd2;
            imm_d    = id_imm;
            rs1_d    = id_rs1;
            rs2_d    = id_rs2;
            rd_d     = id_rd;
            funct3_d = id_funct3;
            funct7_d = id_funct7;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            funct7_q    <= funct7_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_ctrl   = ctrl_q;
    assign ex_pc     = pc_q;
    assign ex_rd1    = rd1_q;
    assign ex_rd2    = rd2_q;
    assign ex_imm    = imm_q;
    assign ex_rs1    = rs1_q;
    assign ex_rs2    = rs2_q;
    assign ex_rd     = rd_q;
    assign ex_funct3 = funct3_q;
    assign ex_funct7 = funct7_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic clk = 1'b0;
    logic reset;
    logic id_valid;
    logic [6:0] id_opcode;
    logic [10:0] id_ctrl;
    logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic [2:0] id_funct3;
    logic [6:0] id_funct7;
    logic ex_flush;
    logic ex_valid;
    logic [10:0] ex_ctrl;
    logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [RW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0] ex_funct3;
    logic [6:0] ex_funct7;
    logic stall;
    logic [CW-1:0] stall_cnt, flush_cnt;

    id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_ctrl(id_ctrl), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: what EX should hold, as a record of the last accepted instruction.
    typedef struct packed {
        logic          valid;
        logic [10:0]   ctrl;
        logic [DW-1:0] pc, rd1, rd2, imm;
        logic [RW-1:0] rs1, rs2, rd;
        logic [2:0]    f3;
        logic [6:0]    f7;
    } ex_rec_t;

    ex_rec_t m_ex;
    int      m_stalls;
    int      m_flushes;
    logic    e_stall;
    logic    o_stall;

    function automatic logic reads_rs1(input logic [6:0] op);
        return op == OP_R || op == OP_I || op == OP_LOAD || op == OP_ST || op == OP_BR || op == OP_JALR;
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op == OP_R || op == OP_ST || op == OP_BR;
    endfunction

    // Control bundle with the load's MemRead in bit 6 of the 11-bit field.
    function automatic logic [10:0] ctrl_for(input logic [6:0] op);
        case (op)
            OP_LOAD: return 11'b011110_00000;
            OP_ST:   return 11'b010001_00000;
            OP_R:    return 11'b000100_10000;
            OP_I:    return 11'b010100_10000;
            OP_BR:   return 11'b000000_01100;
            OP_JAL:  return 11'b000100_00001;
            OP_JALR: return 11'b010100_00010;
            OP_LUI:  return 11'b010100_00000;
            default: return 11'($urandom);
        endcase
    endfunction

    function automatic logic [172:0] dut_vec();
        return {ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_funct3, ex_funct7, stall_cnt, flush_cnt};
    endfunction

    function automatic logic [172:0] model_vec();
        return {m_ex, CW'(m_stalls), CW'(m_flushes)};
    endfunction

    task automatic set_instr(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        id_valid  = 1'b1;
        id_opcode = op;
        id_ctrl   = ctrl_for(op);
        id_rd     = RW'(rd);
        id_rs1    = RW'(rs1);
        id_rs2    = RW'(rs2);
        id_pc     = $urandom;
        id_rd1    = $urandom;
        id_rd2    = $urandom;
        id_imm    = $urandom;
        id_funct3 = 3'($urandom);
        id_funct7 = 7'($urandom);
    endtask

    // One clock: samples stall mid-cycle, predicts it, then advances the model across the edge.
    task automatic tick();
        logic    load_in_ex, dep;
        ex_rec_t nxt;
        #3;
        o_stall    = stall;
        load_in_ex = m_ex.valid && m_ex.ctrl[6] && (m_ex.rd != 0);
        dep        = (reads_rs1(id_opcode) && m_ex.rd == id_rs1) || (reads_rs2(id_opcode) && m_ex.rd == id_rs2);
        e_stall    = id_valid && load_in_ex && dep && !ex_flush && !reset;
        nxt        = '0;
        @(posedge clk);
        if (reset) begin
            m_stalls = 0; m_flushes = 0;
        end else if (ex_flush) begin
            m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
        end else if (id_valid && load_in_ex && dep) begin
            m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
        end else begin
            nxt = '{id_valid, id_valid ? id_ctrl : 11'd0, id_pc, id_rd1, id_rd2, id_imm,
                    id_rs1, id_rs2, id_rd, id_funct3, id_funct7};
        end
        m_ex = nxt;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; ex_flush = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_flush = 1'($urandom);
        set_instr(OP_LOAD, 5, 5, 5);
        tick();
        set_instr(OP_R, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
        tick();
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", o_stall); end
        total++; if (dut_vec() !== 173'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", dut_vec()); end
        reset = 1'b0; ex_flush = 1'b0;
        set_instr(OP_R, 3, 1, 2);
        tick();
        total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_ctrl !== 11'b00010010000) begin
            bad++; $display("FAIL add_latency got valid=%b rd=%0d ctrl=%b want 1/3/00010010000", ex_valid, ex_rd, ex_ctrl);
        end
        total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL add_capture got=%h want=%h", dut_vec(), model_vec()); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(OP_LOAD, 5, 1, 0);
        tick();
        set_instr(OP_R, 6, 5, 7);
        tick();
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", o_stall); end
        total++; if (ex_valid !== 1'b0 || ex_ctrl !== 11'd0) begin bad++; $display("FAIL lu_bubble got valid=%b ctrl=%h want 0/0", ex_valid, ex_ctrl); end
        tick();
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b want=0", o_stall); end
        total++; if (ex_rd !== 5'd6 || ex_valid !== 1'b1 || stall_cnt !== 4'd1) begin
            bad++; $display("FAIL lu_advance got rd=%0d valid=%b cnt=%0d want 6/1/1", ex_rd, ex_valid, stall_cnt);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        set_instr(OP_LOAD, 0, 1, 0);
        tick();
        set_instr(OP_R, 4, 0, 0);
        tick();
        total++; if (o_stall !== 1'b0 || ex_rd !== 5'd4) begin bad++; $display("FAIL x0_load got stall=%b rd=%0d want 0/4", o_stall, ex_rd); end
        set_instr(OP_LOAD, 5, 1, 0);
        tick();
        set_instr(OP_LUI, 5, 5, 5);
        tick();
        total++; if (o_stall !== 1'b0 || ex_valid !== 1'b1 || stall_cnt !== 4'd0) begin
            bad++; $display("FAIL lui_nohaz got stall=%b valid=%b cnt=%0d want 0/1/0", o_stall, ex_valid, stall_cnt);
        end
    endtask

    task automatic test_flush_vs_hazard();
        do_reset();
        set_instr(OP_LOAD, 5, 1, 0);
        tick();
        set_instr(OP_R, 6, 5, 7);
        ex_flush = 1'b1;
        tick();
        ex_flush = 1'b0;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", o_stall); end
        total++; if (ex_valid !== 1'b0 || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            bad++; $display("FAIL flush_bubble got valid=%b fc=%0d sc=%0d want 0/1/0", ex_valid, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_instr(OP_LOAD, 5, 1, 0);
        tick();
        set_instr(OP_ST, 0, 2, 5);
        tick();
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL sw_rs2_stall got=%b want=1", o_stall); end
        tick();
        set_instr(OP_LOAD, 5, 3, 0);
        tick();
        set_instr(OP_BR, 0, 1, 5);
        tick();
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL beq_stall got=%b want=1", o_stall); end
        tick();
        total++; if (stall_cnt !== 4'd2 || ex_opcode_is_branch() !== 1'b1) begin
            bad++; $display("FAIL b2b_count got cnt=%0d ctrl=%b want 2 with branch", stall_cnt, ex_ctrl);
        end
    endtask

    function automatic logic ex_opcode_is_branch();
        return ex_valid && ex_ctrl[2];
    endfunction

    task automatic test_saturation();
        int seen;
        do_reset();
        set_instr(OP_LOAD, 5, 5, 0);
        seen = 0;
        for (int c = 0; c < 200 && seen < (1 << CW) + 3; c++) begin
            tick();
            if (o_stall === 1'b1) seen++;
        end
        total++; if (seen != (1 << CW) + 3) begin bad++; $display("FAIL sat_timeout got=%0d want=%0d", seen, (1 << CW) + 3); end
        total++; if (stall_cnt !== 4'hF) begin bad++; $display("FAIL sat_count got=%0d want=15", stall_cnt); end
        tick();
        #3;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_prestall got=%b want=1", stall); end
        reset = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_dropstall got=%b want=0", stall); end
        tick();
        reset = 1'b0;
        total++; if (ex_valid !== 1'b0 || stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_midstall got valid=%b cnt=%0d want 0/0", ex_valid, stall_cnt); end
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        ops = '{OP_R, OP_I, OP_LOAD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_BAD};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) set_instr(OP_LOAD, $urandom_range(0, 6), 1, 0);
            id_valid = ($urandom_range(0, 5) != 0);
            ex_flush = ($urandom_range(0, 9) == 0);
            tick();
            total++; if (o_stall !== e_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", i, o_stall, e_stall); end
            total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL rnd_state cyc=%0d got=%h want=%h", i, dut_vec(), model_vec()); end
        end
        ex_flush = 1'b0;
    endtask

    initial begin
        m_ex = '0; m_stalls = 0; m_flushes = 0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush_vs_hazard();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
